exe_track_pipe: RTL and testbench
=================================

// Module: exe_track_pipe
// PURPOSE
//  3-slot EXE pipeline tracker: carries in-flight instruction metadata (rd, regWrite, op_type, ltype) and result data
//  through EXE1..EXE3 into WB. Feeds the hazard/forwarding unit its packed per-slot buses; supplies forwarding data
//  for the operand muxes. Owns the dmem load handshake and the 2-stage multiplier.
// PARAMETERS
//  XLEN     32  datapath width
//  RADDR_W   5  register address width
// PORTS
//  clk              in   1            clock, rising edge
//  rst              in   1            synchronous, active-high reset
//  id_valid         in   1            ID/EXE register holds a real instruction
//  reg_DE_flush     in   1            hazard unit bubble request: slot1 loads NOP
//  id_rd            in   RADDR_W      destination register
//  id_regWrite      in   1            instruction writes rd
//  id_op_type       in   2            00 ALU, 01 MEM, 10 MUL, 11 CSR
//  id_ltype         in   1            MEM: 1=load, 0=store
//  id_op_a, id_op_b in   XLEN         resolved operands
//  id_st_data       in   XLEN         store data
//  e1_op_a, e1_op_b out  XLEN         slot1 operands to external ALU
//  alu_res_e1       in   XLEN         combinational ALU result for slot1 (also dmem address)
//  dmem_req         out  1            slot1 MEM op valid (held stable during pipe_hold)
//  dmem_we          out  1            store
//  dmem_addr        out  XLEN         = alu_res_e1
//  dmem_wdata       out  XLEN         slot1 store data
//  dmem_rvalid      in   1            load data valid this cycle
//  dmem_rdata       in   XLEN         load data
//  rdAddr_out_EXE   out  3*RADDR_W    {slot3,slot2,slot1} rd
//  regWrite_out_EXE out  3            per-slot regWrite, gated by slot valid
//  op_type_out_EXE  out  6            per-slot op_type
//  ltype_out_EXE    out  3            per-slot ltype
//  fwd_data_EXE     out  3*XLEN       per-slot forward data
//  pipe_hold        out  1            freezes front end and all slots
//  wb_valid, wb_rd, wb_data  out  1/RADDR_W/XLEN   WB write (wb_valid = slot3 valid & regWrite)
// BEHAVIOUR
//  - Reset: all slot valids 0; every rd/op_type/ltype/data/regWrite output 0; pipe_hold 0; dmem_req 0; wb_valid 0.
//  - pipe_hold = slot2 valid & MEM & load & !dmem_rvalid (combinational). While high, no slot and no mul stage updates.
//  - Advance when !pipe_hold: slot3<=slot2; slot2<=slot1; slot1<=(id_valid & !reg_DE_flush) ? ID fields : bubble.
//    Bubble: valid=0, rd=0, regWrite=0, op_type=0, ltype=0.
//  - Data: slot2.data <= alu_res_e1 (ALU/CSR); slot3.data <= load ? dmem_rdata : MUL ? mul_res : slot2.data.
//  - Forwarding: fwd slot1 = alu_res_e1; fwd slot2 = load ? dmem_rdata : slot2.data; fwd slot3 = slot3.data.
//    Only ALU results are valid in slot1 and MUL is not valid before slot3; the hazard unit stalls those cases.
//  - Latency: ID->WB = 3 cycles plus hold cycles. 1 instruction/cycle throughput.
//  - Store: dmem_we=1 and no rd write. A load with rvalid already high in its slot2 cycle incurs no hold.
//  - Simultaneous pipe_hold & reg_DE_flush: hold wins. Slot1 is unchanged and the flush is dropped; the upstream
//    hazard unit re-evaluates next cycle.
//  - Reset mid-hold: all slots clear the next cycle. An outstanding dmem response after reset is ignored.
//  - Widths: mul_res = low XLEN bits of the unsigned product (wrap-around).
// CONFIGURATION
//  EXE_PERF_CNT_EN defined: adds out ports perf_hold_cnt[31:0] (+1 per pipe_hold cycle) and
//    perf_bubble_cnt[31:0] (+1 per advance loading a bubble into slot1). Both reset to 0, wrap at 2^32.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  exe_pkg: OP_ALU/OP_MEM/OP_MUL/OP_CSR encodings, N_EXE=3, exe_slot_t struct {valid, rd, regWrite, op_type, ltype, data}.
//  Sub-module mul_pipe2: 2-stage multiplier with shared enable = !pipe_hold.
//    Stage A registers a*b[15:0] and a*b[31:16]; stage B sums (a*b[31:16])<<16 + a*b[15:0].
//    Result is aligned with slot3 capture.
// TESTING
//  1 ALU: id rd=5 regWrite=1 op=00, alu_res_e1=0x10 -> next cycle slot2 rd=5 & fwd slot2=0x10;
//    wb_valid=1 rd=5 data=0x10 3 cycles after ID.
//  2 Load fast: rd=7 load, rvalid=1 rdata=0xDEADBEEF in its slot2 cycle -> pipe_hold never asserts;
//    wb data 0xDEADBEEF; fwd slot2=0xDEADBEEF that cycle.
//  3 Load slow: rvalid delayed 3 cycles -> pipe_hold high exactly 3 cycles; all slot outputs frozen;
//    wb_valid=0 throughout; resumes in order.
//  4 MUL 0xFFFFFFFF*0x2 -> op_type_out_EXE shows 10 in slot1 then slot2; wb_data=0xFFFFFFFE.
//  5 reg_DE_flush=1 with id_valid=1 -> regWrite_out_EXE[0]=0, rdAddr slot1=0.
//    Same stimulus during pipe_hold -> slot1 unchanged.
//  6 rst during pipe_hold -> next cycle all outputs 0 and pipe_hold=0.
//    With EXE_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the EXE tracking pipeline: op encodings, slot record, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exe_pkg;

   localparam int EXE_XLEN    = 32;
   localparam int EXE_RADDR_W = 5;
   localparam int N_EXE       = 3;

   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_CSR = 2'b11;

   // One in-flight instruction. In slot1 'data' carries the store data,
   // in slot2/slot3 it carries the result produced so far.
   typedef struct packed {
      logic                   valid;
      logic [EXE_RADDR_W-1:0] rd;
      logic                   reg_write;
      logic [1:0]             op_type;
      logic                   ltype;
      logic [EXE_XLEN-1:0]    data;
   } exe_slot_t;

   function automatic logic is_load(input exe_slot_t s);
      return s.valid && (s.op_type == OP_MEM) && s.ltype;
   endfunction

endpackage

// File: rtl/exe_track_pipe_mul.sv
// Two-stage unsigned multiplier (low XLEN bits of product), stages advance together on i_en.
// Latency: stage A registered here; stage B sum is combinational and captured by the slot3 register.
// Backpressure: i_en low freezes stage A so the partials stay aligned with the held slots.
// Ports: i_clk/i_rst clock and sync reset, i_en shared advance, i_a/i_b operands, o_res wrapped product.
module mul_pipe2 #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_res
);

   localparam int HALF = XLEN / 2;

   // Only the bits that survive the final XLEN-wide wrap are kept:
   // a*b_lo truncated to XLEN, and a*b_hi truncated to HALF (it is shifted up by HALF).
   logic [XLEN-1:0] r_p_lo;
   logic [HALF-1:0] r_p_hi;
   logic [XLEN-1:0] w_b_lo;

   assign w_b_lo = {{HALF{1'b0}}, i_b[HALF-1:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_p_lo <= '0;
         r_p_hi <= '0;
      end else if (i_en) begin
         r_p_lo <= i_a * w_b_lo;
         r_p_hi <= i_a[HALF-1:0] * i_b[XLEN-1:HALF];
      end
   end

   assign o_res = {r_p_hi, {HALF{1'b0}}} + r_p_lo;

endmodule

// File: rtl/exe_track_pipe.sv
// EXE1..EXE3 instruction tracker: slot metadata/data to WB, hazard buses, forwarding data, dmem handshake, MUL.
// Latency: ID->WB 3 cycles plus any hold cycles; one instruction per cycle.
// Backpressure: o_pipe_hold (slot2 load waiting on i_dmem_rvalid) freezes all slots, the multiplier and the front end.
// Ports: i_id_* ID/EXE fields, o_e1_op_* slot1 operands to ALU, i_alu_res_e1 ALU result, o_dmem_*/i_dmem_* data memory,
//        o_*_exe packed {slot3,slot2,slot1} hazard buses, o_fwd_data_exe forwarding data, o_wb_* register write.
// Optional: EXE_PERF_CNT_EN adds o_perf_hold_cnt and o_perf_bubble_cnt.
module exe_track_pipe
   import exe_pkg::*;
#(
   parameter int XLEN    = EXE_XLEN,
   parameter int RADDR_W = EXE_RADDR_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_id_valid,
   input  logic                 i_reg_de_flush,
   input  logic [RADDR_W-1:0]   i_id_rd,
   input  logic                 i_id_reg_write,
   input  logic [1:0]           i_id_op_type,
   input  logic                 i_id_ltype,
   input  logic [XLEN-1:0]      i_id_op_a,
   input  logic [XLEN-1:0]      i_id_op_b,
   input  logic [XLEN-1:0]      i_id_st_data,
   output logic [XLEN-1:0]      o_e1_op_a,
   output logic [XLEN-1:0]      o_e1_op_b,
   input  logic [XLEN-1:0]      i_alu_res_e1,
   output logic                 o_dmem_req,
   output logic                 o_dmem_we,
   output logic [XLEN-1:0]      o_dmem_addr,
   output logic [XLEN-1:0]      o_dmem_wdata,
   input  logic                 i_dmem_rvalid,
   input  logic [XLEN-1:0]      i_dmem_rdata,
   output logic [3*RADDR_W-1:0] o_rd_addr_exe,
   output logic [2:0]           o_reg_write_exe,
   output logic [5:0]           o_op_type_exe,
   output logic [2:0]           o_ltype_exe,
   output logic [3*XLEN-1:0]    o_fwd_data_exe,
   output logic                 o_pipe_hold,
`ifdef EXE_PERF_CNT_EN
   output logic [31:0]          o_perf_hold_cnt,
   output logic [31:0]          o_perf_bubble_cnt,
`endif
   output logic                 o_wb_valid,
   output logic [RADDR_W-1:0]   o_wb_rd,
   output logic [XLEN-1:0]      o_wb_data
);

   exe_slot_t       r_s1, r_s2, r_s3;
   exe_slot_t       w_s1_nxt, w_s2_nxt, w_s3_nxt;
   logic [XLEN-1:0] r_e1_op_a, r_e1_op_b;
   logic [XLEN-1:0] w_s2_fwd, w_mul_res;
   logic            w_s2_load, w_pipe_hold, w_advance, w_id_take;

   assign w_s2_load   = is_load(r_s2);
   assign w_pipe_hold = w_s2_load & ~i_dmem_rvalid;
   assign w_advance   = ~w_pipe_hold;
   assign w_id_take   = i_id_valid & ~i_reg_de_flush;

   // A load's result exists only as the live dmem response while it sits in slot2.
   assign w_s2_fwd = w_s2_load ? i_dmem_rdata : r_s2.data;

   always_comb begin
      w_s1_nxt = '0;
      if (w_id_take) begin
         w_s1_nxt.valid     = 1'b1;
         w_s1_nxt.rd        = i_id_rd;
         w_s1_nxt.reg_write = i_id_reg_write;
         w_s1_nxt.op_type   = i_id_op_type;
         w_s1_nxt.ltype     = i_id_ltype;
         w_s1_nxt.data      = i_id_st_data;
      end

      w_s2_nxt      = r_s1;
      w_s2_nxt.data = i_alu_res_e1;

      w_s3_nxt      = r_s2;
      w_s3_nxt.data = (r_s2.op_type == OP_MUL) ? w_mul_res : w_s2_fwd;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         r_e1_op_a <= '0;
         r_e1_op_b <= '0;
      end else if (w_advance) begin
         r_s1      <= w_s1_nxt;
         r_s2      <= w_s2_nxt;
         r_s3      <= w_s3_nxt;
         r_e1_op_a <= w_id_take ? i_id_op_a : '0;
         r_e1_op_b <= w_id_take ? i_id_op_b : '0;
      end
   end

   // Stage A samples slot1 operands on the slot1->slot2 advance; its sum is
   // captured into slot3 on the following advance.
   mul_pipe2 #(.XLEN(XLEN)) u_mul (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_advance),
      .i_a   (r_e1_op_a),
      .i_b   (r_e1_op_b),
      .o_res (w_mul_res)
   );

   assign o_e1_op_a    = r_e1_op_a;
   assign o_e1_op_b    = r_e1_op_b;
   assign o_dmem_req   = r_s1.valid & (r_s1.op_type == OP_MEM);
   assign o_dmem_we    = o_dmem_req & ~r_s1.ltype;
   assign o_dmem_addr  = i_alu_res_e1;
   assign o_dmem_wdata = r_s1.data;

   assign o_rd_addr_exe   = {r_s3.rd, r_s2.rd, r_s1.rd};
   assign o_reg_write_exe = {r_s3.valid & r_s3.reg_write,
                             r_s2.valid & r_s2.reg_write,
                             r_s1.valid & r_s1.reg_write};
   assign o_op_type_exe   = {r_s3.op_type, r_s2.op_type, r_s1.op_type};
   assign o_ltype_exe     = {r_s3.ltype, r_s2.ltype, r_s1.ltype};
   assign o_fwd_data_exe  = {r_s3.data, w_s2_fwd, i_alu_res_e1};
   assign o_pipe_hold     = w_pipe_hold;

   assign o_wb_valid = r_s3.valid & r_s3.reg_write;
   assign o_wb_rd    = r_s3.rd;
   assign o_wb_data  = r_s3.data;

`ifdef EXE_PERF_CNT_EN
   logic [31:0] r_perf_hold_cnt, r_perf_bubble_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_hold_cnt   <= '0;
         r_perf_bubble_cnt <= '0;
      end else begin
         if (w_pipe_hold) r_perf_hold_cnt <= r_perf_hold_cnt + 32'd1;
         if (w_advance && !w_id_take) r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
   end

   assign o_perf_hold_cnt   = r_perf_hold_cnt;
   assign o_perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_exe_track_pipe.sv
// Directed self-checking bench for exe_track_pipe.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_exe_track_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, flush, id_rw, id_lt;
   logic [4:0]  id_rd;
   logic [1:0]  id_op;
   logic [31:0] id_a, id_b, id_st;
   logic [31:0] e1_a, e1_b, alu_res;
   logic        dmem_req, dmem_we, rvalid;
   logic [31:0] dmem_addr, dmem_wdata, rdata;
   logic [14:0] rd_addr;
   logic [2:0]  regw, ltype;
   logic [5:0]  op_type;
   logic [95:0] fwd;
   logic        hold, wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef EXE_PERF_CNT_EN
   logic [31:0] perf_hold, perf_bubble;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // External ALU: a simple adder is enough to give every slot1 result a known value.
   assign alu_res = e1_a + e1_b;

   exe_track_pipe dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_id_valid      (id_valid),
      .i_reg_de_flush  (flush),
      .i_id_rd         (id_rd),
      .i_id_reg_write  (id_rw),
      .i_id_op_type    (id_op),
      .i_id_ltype      (id_lt),
      .i_id_op_a       (id_a),
      .i_id_op_b       (id_b),
      .i_id_st_data    (id_st),
      .o_e1_op_a       (e1_a),
      .o_e1_op_b       (e1_b),
      .i_alu_res_e1    (alu_res),
      .o_dmem_req      (dmem_req),
      .o_dmem_we       (dmem_we),
      .o_dmem_addr     (dmem_addr),
      .o_dmem_wdata    (dmem_wdata),
      .i_dmem_rvalid   (rvalid),
      .i_dmem_rdata    (rdata),
      .o_rd_addr_exe   (rd_addr),
      .o_reg_write_exe (regw),
      .o_op_type_exe   (op_type),
      .o_ltype_exe     (ltype),
      .o_fwd_data_exe  (fwd),
      .o_pipe_hold     (hold),
`ifdef EXE_PERF_CNT_EN
      .o_perf_hold_cnt   (perf_hold),
      .o_perf_bubble_cnt (perf_bubble),
`endif
      .o_wb_valid      (wb_valid),
      .o_wb_rd         (wb_rd),
      .o_wb_data       (wb_data)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      id_valid = 1'b0; flush = 1'b0; id_rd = '0; id_rw = 1'b0;
      id_op = 2'b00; id_lt = 1'b0; id_a = '0; id_b = '0; id_st = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] op,
                        input logic lt, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] st);
      id_valid = 1'b1; flush = 1'b0; id_rd = rd; id_rw = rw;
      id_op = op; id_lt = lt; id_a = a; id_b = b; id_st = st;
   endtask

   initial begin
      rst = 1'b1; rvalid = 1'b0; rdata = '0;
      idle();

      // Reset state
      tick(); tick(); #1;
      chk("rst_hold", hold, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_regw", regw, 0);
      chk("rst_op_type", op_type, 0);
      chk("rst_ltype", ltype, 0);
      chk("rst_fwd", fwd, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
      rst = 1'b0;

      // 1: ALU rd=5, 8+8=0x10
      issue(5'd5, 1'b1, 2'b00, 1'b0, 32'h8, 32'h8, 32'h0);
      tick(); idle(); #1;
      chk("alu_s1_rd", rd_addr[4:0], 5);
      chk("alu_s1_regw", regw, 3'b001);
      chk("alu_s1_fwd", fwd[31:0], 32'h10);
      tick(); #1;
      chk("alu_s2_rd", rd_addr[9:5], 5);
      chk("alu_s2_fwd", fwd[63:32], 32'h10);
      tick(); #1;
      chk("alu_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd5, 32'h10});
      chk("alu_s3_fwd", fwd[95:64], 32'h10);
      repeat (3) tick();

      // 2: fast load rd=7, data ready in its slot2 cycle
      issue(5'd7, 1'b1, 2'b01, 1'b1, 32'h100, 32'h4, 32'h0);
      tick(); idle(); #1;
      chk("ldf_req", {dmem_req, dmem_we}, 2'b10);
      chk("ldf_addr", dmem_addr, 32'h104);
      chk("ldf_hold_s1", hold, 0);
      tick(); rvalid = 1'b1; rdata = 32'hDEADBEEF; #1;
      chk("ldf_hold_s2", hold, 0);
      chk("ldf_fwd_s2", fwd[63:32], 32'hDEADBEEF);
      tick(); rvalid = 1'b0; rdata = '0; #1;
      chk("ldf_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd7, 32'hDEADBEEF});
      chk("ldf_hold_s3", hold, 0);
      repeat (3) tick();

      // Store: dmem_we with store data, no register write
      issue(5'd0, 1'b0, 2'b01, 1'b0, 32'h40, 32'h4, 32'h0000A5A5);
      tick(); idle(); #1;
      chk("st_req_we", {dmem_req, dmem_we}, 2'b11);
      chk("st_wdata", dmem_wdata, 32'h0000A5A5);
      chk("st_regw", regw, 0);
      tick(); #1;
      chk("st_no_hold", hold, 0);
      repeat (3) tick();

      // 3: slow load rd=9 followed by ALU rd=10 (1+2), response 3 cycles late
      issue(5'd9, 1'b1, 2'b01, 1'b1, 32'h200, 32'h0, 32'h0);
      tick();
      issue(5'd10, 1'b1, 2'b00, 1'b0, 32'h1, 32'h2, 32'h0);
      tick(); idle(); #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            tick(); #1;
         end
         chk("lds_hold", hold, 1);
         chk("lds_rd_frozen", rd_addr, {5'd0, 5'd9, 5'd10});
         chk("lds_regw_frozen", regw, 3'b011);
         chk("lds_wb_valid", wb_valid, 0);
      end
      tick(); rvalid = 1'b1; rdata = 32'hCAFE0001; #1;
      chk("lds_release", hold, 0);
`ifdef EXE_PERF_CNT_EN
      chk("perf_hold_3", perf_hold, 3);
`endif
      tick(); rvalid = 1'b0; rdata = '0; #1;
      chk("lds_wb_load", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd9, 32'hCAFE0001});
      tick(); #1;
      chk("lds_wb_alu", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd10, 32'h3});
      repeat (3) tick();

      // 4: back-to-back MULs
      issue(5'd12, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h0);
      tick();
      issue(5'd13, 1'b1, 2'b10, 1'b0, 32'h12345678, 32'h00010001, 32'h0);
      #1;
      chk("mul_op_s1", op_type[1:0], 2'b10);
      tick(); idle(); #1;
      chk("mul_op_s2", op_type, 6'b001010);
      tick(); #1;
      chk("mul_wb_a", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd12, 32'hFFFFFFFE});
      chk("mul_op_s3", op_type, 6'b101000);
      tick(); #1;
      chk("mul_wb_b", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd13, 32'h68AC5678});
      repeat (3) tick();

      // 5a: flush with a valid ID instruction loads a bubble
      issue(5'd20, 1'b1, 2'b00, 1'b0, 32'h1, 32'h1, 32'h0);
      flush = 1'b1;
      tick(); idle(); #1;
      chk("flush_regw", regw[0], 0);
      chk("flush_rd", rd_addr[4:0], 0);

      // 5b: flush during a hold is dropped, slot1 keeps ALU rd=15 (5+5)
      issue(5'd14, 1'b1, 2'b01, 1'b1, 32'h300, 32'h0, 32'h0);
      tick();
      issue(5'd15, 1'b1, 2'b00, 1'b0, 32'h5, 32'h5, 32'h0);
      tick();
      issue(5'd16, 1'b1, 2'b00, 1'b0, 32'h7, 32'h7, 32'h0);
      flush = 1'b1; #1;
      chk("hflush_hold", hold, 1);
      tick(); #1;
      chk("hflush_s1_rd", rd_addr[4:0], 15);
      chk("hflush_s1_regw", regw[0], 1);
      chk("hflush_s1_fwd", fwd[31:0], 32'hA);
      flush = 1'b0; rvalid = 1'b1; rdata = 32'h00001234; #1;
      chk("hflush_release", hold, 0);
      tick(); rvalid = 1'b0; rdata = '0; idle(); #1;
      chk("hflush_s1_next", rd_addr[4:0], 16);
      chk("hflush_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd14, 32'h00001234});
      repeat (3) tick();

      // 6: reset during a hold, late response afterwards is ignored
      issue(5'd17, 1'b1, 2'b01, 1'b1, 32'h400, 32'h0, 32'h0);
      tick(); idle();
      tick(); #1;
      chk("rhold_hold", hold, 1);
      rst = 1'b1;
      tick(); rst = 1'b0; rvalid = 1'b1; rdata = 32'h00000BAD; #1;
      chk("rhold_hold_clr", hold, 0);
      chk("rhold_rd_addr", rd_addr, 0);
      chk("rhold_regw", regw, 0);
      chk("rhold_op_lt", {op_type, ltype}, 0);
      chk("rhold_fwd", fwd, 0);
      chk("rhold_dmem_req", dmem_req, 0);
      chk("rhold_wb", {wb_valid, wb_rd, wb_data}, 0);
`ifdef EXE_PERF_CNT_EN
      chk("rhold_perf", {perf_hold, perf_bubble}, 0);
`endif
      tick(); rvalid = 1'b0; rdata = '0; #1;
      chk("rhold_wb_after", wb_valid, 0);
      chk("rhold_hold_after", hold, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
